qmd_seq: RTL
============

# qmd_seq

Multiply/divide step sequencer for the Q register. On a start request it takes over Q control for a fixed 32-step iterative multiply (shift right, conditional add) or non-restoring divide (shift left, add/subtract). For each step it issues the Q shift/load selects, the ALU add/sub/pass select and the Q serial input bit. It sits between the microcode decode and the existing Q control logic, and advances only on the processor's write-state strobe.

## Interface
Parameters:
- STEPS, 32, number of shift steps per operation (counter width is clog2(STEPS)+1)

Ports:
- clk  in  1  processor clock
- reset_n  in  1  asynchronous active-low reset
- state_write  in  1  advance strobe; the FSM moves only in cycles where this is high (except abort)
- start  in  1  operation request, sampled in IDLE with state_write
- op  in  1  0 = multiply, 1 = divide; captured at start
- divisor_zero  in  1  divisor-is-zero flag, captured at start
- abort  in  1  cancel the operation; acts on the next clk edge regardless of state_write
- q0  in  1  current Q[0] (multiplier LSB)
- alu_sign  in  1  sign of the current ALU result (divide decision)
- qs0, qs1  out  1  Q selects: 00 hold, 01 shift left, 10 shift right, 11 load
- alu_sel  out  2  00 pass, 01 add, 10 subtract
- q_in  out  1  serial bit shifted into Q
- busy  out  1  high in every state except IDLE
- done  out  1  high in DONE
- err  out  1  divide-by-zero result flag; holds until the next accepted start
- step_count  out  6  completed steps

## Operation
- States: IDLE, LOAD, STEP, FIXUP (macro only), DONE.
- IDLE:
  - On start & state_write, capture op and divisor_zero and go to LOAD.
  - start without state_write is ignored.
- LOAD:
  - Drive qs=11 to load the operand into Q.
  - Clear step_count and the prior-sign register.
  - Next state: DONE with err=1 if divide and divisor_zero; otherwise STEP.
- STEP, multiply:
  - qs=10.
  - alu_sel=add when q0=1, pass when q0=0.
  - q_in=0.
- STEP, divide:
  - qs=01.
  - alu_sel=subtract when the prior sign is 0, add when it is 1. The prior sign is alu_sign registered on the previous step and is 0 for the first step.
  - q_in = ~alu_sign.
- Step counting:
  - step_count increments on each state_write in STEP.
  - When step_count reaches STEPS-1 and state_write is high, go to FIXUP if the macro is defined, otherwise DONE.
- DONE:
  - done=1 for one advance.
  - Next state_write returns to IDLE.
  - A start presented in DONE is ignored.
- Abort:
  - abort in any state sends the FSM to IDLE on the next edge.
  - step_count is cleared and err is cleared.
  - Abort wins over a simultaneous start.
- Reset values: IDLE, qs0=qs1=0, alu_sel=00, q_in=0, busy=0, done=0, err=0, step_count=0.

## Timing
- qs0, qs1, alu_sel and q_in are combinational from state and inputs, gated by state_write. They are all 0 in any cycle where state_write is low, so Q only moves on strobe cycles.
- busy, done, err and step_count are registered.
- Latency from an accepted start to done:
  - 1 + STEPS + 1 advances: 34 when STEPS=32.
  - 35 advances with the macro.
  - 2 advances on divide-by-zero.
- Gaps in state_write stretch an operation without changing its results or step order.
- step_count never wraps. It saturates at STEPS until LOAD or abort.

## Configuration
- QMD_SIGNED_FIXUP_EN defined:
  - Adds the FIXUP state for one advance after the last step.
  - For divide with prior sign 1: alu_sel=add (remainder restore), qs=00.
  - For multiply, or divide with prior sign 0: alu_sel=pass, qs=00.
- QMD_SIGNED_FIXUP_EN undefined: STEP goes directly to DONE and the FIXUP encoding is unused.

## Structure
- Package qmd_pkg holds:
  - the state enum;
  - the QS_HOLD/QS_SHL/QS_SHR/QS_LOAD codes;
  - the ALU_PASS/ALU_ADD/ALU_SUB codes;
  - the default STEPS.
- One sub-module, qmd_decode: purely combinational mapping from {state, op, q0, alu_sign, prior sign, state_write} to qs/alu_sel/q_in, so the decode can be checked on its own.

## Test plan
- Multiply, state_write held high, start with op=0, q0 pattern 1,0,1,0…:
  - LOAD shows qs=11.
  - The 32 steps show qs=10 with alu_sel alternating 01/00.
  - done is high 34 cycles after start.
  - step_count=32.
- Divide, alu_sign driven 0 then 1 then 0:
  - alu_sel runs 10, 10, 01, 10.
  - q_in is the inverse of each alu_sign.
  - qs=01 on every step.
- state_write toggled 1-of-3 during a multiply:
  - qs is 00 in every non-strobe cycle.
  - done is reached after exactly 34 strobes.
- Divide with divisor_zero=1: LOAD, then DONE with err=1, no STEP cycles, step_count=0.
- abort asserted at step 10 together with start:
  - Next cycle is IDLE with busy=0 and step_count=0.
  - A later start is accepted normally.
- With QMD_SIGNED_FIXUP_EN, divide ending with prior sign 1: FIXUP shows alu_sel=01, qs=00, and done arrives after 35 strobes.

Source files
------------

// File: rtl/qmd_pkg.sv
// qmd_pkg: shared types and codes for the Q multiply/divide step sequencer.
//   qmd_state_e   - sequencer state encoding
//   QS_*          - Q select codes, written as {qs1, qs0}
//   ALU_*         - ALU function select codes
//   STEPS_DEFAULT - default number of shift steps per operation
package qmd_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStep  = 3'd2,
        StFixup = 3'd3,
        StDone  = 3'd4
    } qmd_state_e;

    // {qs1, qs0}
    localparam logic [1:0] QS_HOLD = 2'b00;
    localparam logic [1:0] QS_SHL  = 2'b01;
    localparam logic [1:0] QS_SHR  = 2'b10;
    localparam logic [1:0] QS_LOAD = 2'b11;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam int unsigned STEPS_DEFAULT = 32;

endpackage

// File: rtl/qmd_decode.sv
// qmd_decode: combinational mapping from sequencer state and step inputs to the
// Q select, ALU select and Q serial-input bit. All outputs are zero (hold/pass)
// in cycles without state_write so Q only moves on strobe cycles.
// Optional feature macro: QMD_SIGNED_FIXUP_EN (decodes the FIXUP state).
// Ports:
//   state_i       - current sequencer state
//   op_i          - captured operation, 0 multiply / 1 divide
//   q0_i          - current Q[0]
//   alu_sign_i    - sign of the current ALU result
//   prior_sign_i  - ALU sign registered on the previous divide step
//   state_write_i - advance strobe
//   qs_o          - Q select {qs1, qs0}
//   alu_sel_o     - ALU function select
//   q_in_o        - serial bit shifted into Q
module qmd_decode
    import qmd_pkg::*;
(
    input  qmd_state_e state_i,
    input  logic       op_i,
    input  logic       q0_i,
    input  logic       alu_sign_i,
    input  logic       prior_sign_i,
    input  logic       state_write_i,
    output logic [1:0] qs_o,
    output logic [1:0] alu_sel_o,
    output logic       q_in_o
);

    always_comb begin
        qs_o      = QS_HOLD;
        alu_sel_o = ALU_PASS;
        q_in_o    = 1'b0;
        if (state_write_i) begin
            unique case (state_i)
                StLoad: qs_o = QS_LOAD;
                StStep: begin
                    if (op_i) begin
                        // Non-restoring divide: subtract after a non-negative
                        // partial remainder, add back after a negative one.
                        qs_o      = QS_SHL;
                        alu_sel_o = prior_sign_i ? ALU_ADD : ALU_SUB;
                        q_in_o    = ~alu_sign_i;
                    end else begin
                        qs_o      = QS_SHR;
                        alu_sel_o = q0_i ? ALU_ADD : ALU_PASS;
                    end
                end
`ifdef QMD_SIGNED_FIXUP_EN
                // Restore a negative final remainder; Q is held.
                StFixup: alu_sel_o = (op_i && prior_sign_i) ? ALU_ADD : ALU_PASS;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qmd_seq.sv
// qmd_seq: multiply/divide step sequencer for the Q register. On an accepted
// start it runs LOAD, STEPS shift steps (multiply: shift right with
// conditional add; divide: non-restoring shift left with add/subtract) and
// DONE, advancing only on state_write. abort returns to IDLE on the next edge.
// Optional feature macro: QMD_SIGNED_FIXUP_EN adds a one-advance FIXUP state
// after the last step.
// Ports:
//   clk_i, reset_n_i - clock, asynchronous active-low reset
//   state_write_i    - advance strobe
//   start_i          - operation request (sampled in IDLE with state_write)
//   op_i             - 0 multiply, 1 divide (captured at start)
//   divisor_zero_i   - divisor-is-zero flag (captured at start)
//   abort_i          - cancel, acts regardless of state_write
//   q0_i             - current Q[0]
//   alu_sign_i       - sign of the current ALU result
//   qs0_o, qs1_o     - Q selects (combinational)
//   alu_sel_o        - ALU select (combinational)
//   q_in_o           - Q serial input (combinational)
//   busy_o, done_o   - registered status
//   err_o            - registered divide-by-zero flag
//   step_count_o     - registered count of completed steps
module qmd_seq
    import qmd_pkg::*;
#(
    parameter int unsigned STEPS = STEPS_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   state_write_i,
    input  logic                   start_i,
    input  logic                   op_i,
    input  logic                   divisor_zero_i,
    input  logic                   abort_i,
    input  logic                   q0_i,
    input  logic                   alu_sign_i,
    output logic                   qs0_o,
    output logic                   qs1_o,
    output logic [1:0]             alu_sel_o,
    output logic                   q_in_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [$clog2(STEPS):0] step_count_o
);

    localparam int unsigned CW = $clog2(STEPS) + 1;

    qmd_state_e    state_q, state_d;
    logic          busy_q, done_q, err_q;
    logic          op_q, dz_q, prior_q;
    logic [CW-1:0] cnt_q;
    logic          last_step;
    logic [1:0]    qs;

    assign last_step = (cnt_q == CW'(STEPS - 1));

    // State register plus the status flags derived from the next state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

    // Next-state logic; abort overrides everything, including a start.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else if (state_write_i) begin
            unique case (state_q)
                StIdle:  if (start_i) state_d = StLoad;
                StLoad:  state_d = (op_q && dz_q) ? StDone : StStep;
                StStep: begin
                    if (last_step) begin
`ifdef QMD_SIGNED_FIXUP_EN
                        state_d = StFixup;
`else
                        state_d = StDone;
`endif
                    end
                end
                StFixup: state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Operation context, step counter, prior sign and error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            op_q    <= 1'b0;
            dz_q    <= 1'b0;
            prior_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (abort_i) begin
            prior_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (state_write_i) begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        dz_q  <= divisor_zero_i;
                        err_q <= 1'b0;
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    prior_q <= 1'b0;
                    if (op_q && dz_q) err_q <= 1'b1;
                end
                StStep: begin
                    // Saturate rather than wrap.
                    if (cnt_q < CW'(STEPS)) cnt_q <= cnt_q + CW'(1);
                    prior_q <= alu_sign_i;
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    qmd_decode u_decode (
        .state_i       (state_q),
        .op_i          (op_q),
        .q0_i          (q0_i),
        .alu_sign_i    (alu_sign_i),
        .prior_sign_i  (prior_q),
        .state_write_i (state_write_i),
        .qs_o          (qs),
        .alu_sel_o     (alu_sel_o),
        .q_in_o        (q_in_o)
    );

    assign qs0_o        = qs[0];
    assign qs1_o        = qs[1];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign step_count_o = cnt_q;

endmodule
